fp32_div: RTL and testbench

FP32_DIV -- requirements
Module: fp32_div

---
 rtl/fp32_pkg.sv | 19 +
 rtl/fp32_unpack.sv | 21 ++
 rtl/fp32_div.sv | 143 ++++++++++++++
 tb/tb_fp32_div.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/fp32_pkg.sv
// Shared IEEE-754 single-precision constants, field widths and the divider FSM state type.
package fp32_pkg;

    localparam int unsigned SIGN_W = 1;
    localparam int unsigned EXP_W  = 8;
    localparam int unsigned MANT_W = 23;

    localparam logic [31:0]      QNAN    = 32'h7FC00001;
    localparam int               BIAS    = 127;
    localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/fp32_unpack.sv
// Splits an fp32 word into fields and classifies it; exp=0 inputs are flushed to zero.
module fp32_unpack
    import fp32_pkg::*;
(
    input  logic [31:0]       i_val,
    output logic              o_sign,
    output logic [EXP_W-1:0]  o_exp,
    output logic [MANT_W-1:0] o_mant,
    output logic              o_is_zero,
    output logic              o_is_inf,
    output logic              o_is_nan
);

    assign o_sign    = i_val[31];
    assign o_exp     = i_val[30:23];
    assign o_mant    = i_val[22:0];
    assign o_is_zero = (o_exp == '0);
    assign o_is_inf  = (o_exp == EXP_MAX) && (o_mant == '0);
    assign o_is_nan  = (o_exp == EXP_MAX) && (o_mant != '0);

endmodule

// File: rtl/fp32_div.sv
// Multi-cycle fp32 divider: restoring radix-2 mantissa divide, truncating, flush-to-zero.
module fp32_div
    import fp32_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result
);

    logic              w_sa, w_sb;
    logic [EXP_W-1:0]  w_ea, w_eb;
    logic [MANT_W-1:0] w_ma, w_mb;
    logic              w_za, w_zb, w_ia, w_ib, w_na, w_nb;

    fp32_unpack u_unpack_a (
        .i_val(a), .o_sign(w_sa), .o_exp(w_ea), .o_mant(w_ma),
        .o_is_zero(w_za), .o_is_inf(w_ia), .o_is_nan(w_na)
    );

    fp32_unpack u_unpack_b (
        .i_val(b), .o_sign(w_sb), .o_exp(w_eb), .o_mant(w_mb),
        .o_is_zero(w_zb), .o_is_inf(w_ib), .o_is_nan(w_nb)
    );

    state_t             r_state;
    logic               r_sign;
    logic signed [9:0]  r_exp;
    logic [24:0]        r_rem;
    logic [23:0]        r_divisor;
    logic [24:0]        r_q;
    logic [4:0]         r_cnt;
    logic [31:0]        r_result;
    logic               r_out_valid;

    logic               w_sign;
    logic               w_special;
    logic [31:0]        w_special_res;
    logic signed [9:0]  w_exp_calc;
    logic               w_ge;
    logic [24:0]        w_rem_next;
    logic signed [9:0]  w_exp_n;
    logic [22:0]        w_mant_n;
    logic [31:0]        w_norm_res;

    assign in_ready  = (r_state == IDLE);
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign w_sign    = w_sa ^ w_sb;

    // Ordering matters: NaN and indeterminate forms win over infinity/zero results.
    always_comb begin
        w_special     = 1'b1;
        w_special_res = '0;
        if (w_na || w_nb)
            w_special_res = QNAN;
        else if ((w_ia && w_ib) || (w_za && w_zb))
            w_special_res = QNAN;
        else if (w_ia || w_zb)
            w_special_res = {w_sign, EXP_MAX, {MANT_W{1'b0}}};
        else if (w_za || w_ib)
            w_special_res = '0;
        else
            w_special = 1'b0;
    end

    assign w_exp_calc = {2'b00, w_ea} - {2'b00, w_eb} + 10'(BIAS);

    assign w_ge       = (r_rem >= {1'b0, r_divisor});
    assign w_rem_next = w_ge ? ((r_rem - {1'b0, r_divisor}) << 1) : (r_rem << 1);

    assign w_exp_n  = r_q[24] ? r_exp : (r_exp - 10'sd1);
    assign w_mant_n = r_q[24] ? r_q[23:1] : r_q[22:0];

    always_comb begin
        if (w_exp_n >= 10'sd255)
            w_norm_res = {r_sign, EXP_MAX, {MANT_W{1'b0}}};
        else if (w_exp_n <= 10'sd0)
            w_norm_res = '0;
        else
            w_norm_res = {r_sign, w_exp_n[7:0], w_mant_n};
    end

    // out_valid registers one cycle into DONE, giving the fixed 1- and 27-cycle latencies.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_sign      <= 1'b0;
            r_exp       <= '0;
            r_rem       <= '0;
            r_divisor   <= '0;
            r_q         <= '0;
            r_cnt       <= '0;
            r_result    <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_sign    <= w_sign;
                        r_exp     <= w_exp_calc;
                        r_rem     <= {1'b0, 1'b1, w_ma};
                        r_divisor <= {1'b1, w_mb};
                        r_q       <= '0;
                        r_cnt     <= '0;
                        if (w_special) begin
                            r_result <= w_special_res;
                            r_state  <= DONE;
                        end else begin
                            r_state  <= DIV;
                        end
                    end
                end
                DIV: begin
                    r_rem <= w_rem_next;
                    r_q   <= {r_q[23:0], w_ge};
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'd24)
                        r_state <= NORM;
                end
                NORM: begin
                    r_result <= w_norm_res;
                    r_state  <= DONE;
                end
                DONE: begin
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp32_div.sv
// Directed, table-driven bench for fp32_div: results, latency, backpressure and mid-operation reset.
module tb_fp32_div;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;

    int n_pass  = 0;
    int n_total = 0;

    fp32_div dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] va;
        logic [31:0] vb;
        logic [31:0] res;
        int          lat;
    } vec_t;

    vec_t vecs[19];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
        n_total++;
        if (got === expv)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", name, got, expv);
    endtask

    // Waits (bounded) for out_valid, returning cycles since the acceptance edge.
    task automatic wait_out(output int n);
        n = 0;
        while (n < 60) begin
            @(posedge clk); #1;
            n++;
            if (out_valid) break;
        end
    endtask

    task automatic run_op(input string name, input logic [31:0] ta, input logic [31:0] tb,
                          input logic [31:0] exp_res, input int exp_lat);
        int n;
        a = ta; b = tb; in_valid = 1'b1;
        check({name, " in_ready"}, {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 32'hDEADBEEF; b = 32'h12345678;
        wait_out(n);
        check({name, " latency"}, n, exp_lat);
        check({name, " result"}, result, exp_res);
        @(posedge clk); #1;
    endtask

    initial begin
        int n;
        int seen;

        vecs[0]  = '{32'h40C00000, 32'h40000000, 32'h40400000, 27};
        vecs[1]  = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 27};
        vecs[2]  = '{32'h3F800000, 32'h00000000, 32'h7F800000, 1};
        vecs[3]  = '{32'hBF800000, 32'h00000000, 32'hFF800000, 1};
        vecs[4]  = '{32'h00000000, 32'h00000000, 32'h7FC00001, 1};
        vecs[5]  = '{32'h7FC00000, 32'h3F800000, 32'h7FC00001, 1};
        vecs[6]  = '{32'h7F000000, 32'h3E800000, 32'h7F800000, 27};
        vecs[7]  = '{32'h00800000, 32'h7F000000, 32'h00000000, 27};
        vecs[8]  = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 27};
        vecs[9]  = '{32'hC0C00000, 32'h40000000, 32'hC0400000, 27};
        vecs[10] = '{32'h3F800000, 32'hC0000000, 32'hBF000000, 27};
        vecs[11] = '{32'h7F800000, 32'h7F800000, 32'h7FC00001, 1};
        vecs[12] = '{32'h7F800000, 32'hBF800000, 32'hFF800000, 1};
        vecs[13] = '{32'h3F800000, 32'h7F800000, 32'h00000000, 1};
        vecs[14] = '{32'h80000000, 32'h3F800000, 32'h00000000, 1};
        vecs[15] = '{32'h00000001, 32'h3F800000, 32'h00000000, 1};
        vecs[16] = '{32'h3F800000, 32'h00000001, 32'h7F800000, 1};
        vecs[17] = '{32'h3F800000, 32'h7FC00000, 32'h7FC00001, 1};
        vecs[18] = '{32'hFF800000, 32'h00000000, 32'hFF800000, 1};

        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset in_ready", {31'b0, in_ready}, 32'd1);
        check("reset out_valid", {31'b0, out_valid}, 32'd0);
        check("reset result", result, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 19; i++)
            run_op($sformatf("vec%0d", i), vecs[i].va, vecs[i].vb, vecs[i].res, vecs[i].lat);

        // Backpressure: result must hold and new requests must be ignored until the handshake.
        out_ready = 1'b0;
        a = 32'h40C00000; b = 32'h40000000; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_out(n);
        check("bp latency", n, 27);
        a = 32'h3F800000; b = 32'h3F800000; in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check($sformatf("bp hold result c%0d", k), result, 32'h40400000);
            check($sformatf("bp hold valid c%0d", k), {31'b0, out_valid}, 32'd1);
            check($sformatf("bp in_ready c%0d", k), {31'b0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp after handshake out_valid", {31'b0, out_valid}, 32'd0);
        check("bp after handshake in_ready", {31'b0, in_ready}, 32'd1);
        seen = 0;
        repeat (35) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("bp ignored request", seen, 0);

        // Reset during DIV abandons the operation.
        a = 32'h3F800000; b = 32'h40400000; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("mid-reset in_ready", {31'b0, in_ready}, 32'd1);
        check("mid-reset out_valid", {31'b0, out_valid}, 32'd0);
        check("mid-reset result", result, 32'h0);
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("aborted op no result", seen, 0);

        run_op("post-reset", 32'h40C00000, 32'h40000000, 32'h40400000, 27);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
